// File: rtl/lbp_pkg.sv
// Shared types and default geometry for the LBP frame host.
package lbp_pkg;

  localparam int LBP_IMG_W  = 128;
  localparam int LBP_IMG_H  = 128;
  localparam int LBP_ADDR_W = 14;
  localparam int LBP_DATA_W = 8;
  localparam int IMG_PIXELS = LBP_IMG_W * LBP_IMG_H;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SERVE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/lbp_frame_ram.sv
// Frame storage: synchronous write port, asynchronous read port, contents not reset.
module lbp_frame_ram #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lbp_frame_host.sv
// Host responder for the LBP engine: loads a gray frame, serves reads, captures
// lbp writes, then drains the result frame in raster order.
module lbp_frame_host #(
  parameter int IMG_W  = lbp_pkg::LBP_IMG_W,
  parameter int IMG_H  = lbp_pkg::LBP_IMG_H,
  parameter int ADDR_W = lbp_pkg::LBP_ADDR_W,
  parameter int DATA_W = lbp_pkg::LBP_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              gray_ready,
  input  logic              gray_req,
  input  logic [ADDR_W-1:0] gray_addr,
  output logic [DATA_W-1:0] gray_data,
  input  logic              lbp_valid,
  input  logic [ADDR_W-1:0] lbp_addr,
  input  logic [DATA_W-1:0] lbp_data,
  input  logic              finish,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic [ADDR_W:0]   lbp_wr_cnt,
  output logic              done,
  output logic [1:0]        fsm_state
);
  import lbp_pkg::*;

  localparam int                N         = IMG_W * IMG_H;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
  localparam logic [ADDR_W:0]   N_EXT     = (ADDR_W + 1)'(N);

  state_t            state, state_next;
  logic [ADDR_W-1:0] ptr, ptr_inc, res_raddr, res_waddr;
  logic [DATA_W-1:0] img_rdata, res_rdata, res_wdata;
  logic              load_xfer, lbp_take, res_we, drain_xfer;

  // Handshakes: a beat moves on a rising edge only when valid and ready are
  // both high; the sender holds data stable while valid is high and ready low.
  assign load_xfer  = (state == LOAD) && in_valid && in_ready;
  assign lbp_take   = (state == SERVE) && gray_ready && lbp_valid
                      && ({1'b0, lbp_addr} < N_EXT);
  assign drain_xfer = (state == DRAIN) && out_valid && out_ready;
  assign ptr_inc    = ptr + 1'b1;
  assign fsm_state  = state;

  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (load_xfer && (ptr == LAST_ADDR)) state_next = SERVE;
      SERVE:   if (finish) state_next = DRAIN;
      DRAIN:   if (drain_xfer && out_last) state_next = DONE;
      DONE:    state_next = DONE;
      default: state_next = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= LOAD;
    else        state <= state_next;
  end

  // LOAD clears the result frame so pixels the engine never writes drain as 0.
  assign res_we    = load_xfer || lbp_take;
  assign res_waddr = load_xfer ? ptr : lbp_addr;
  assign res_wdata = load_xfer ? '0 : lbp_data;
  // While a pixel sits in the output register, look one ahead for the refill.
  assign res_raddr = out_valid ? ptr_inc : ptr;

  lbp_frame_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_img (
    .clk   (clk),
    .we    (load_xfer),
    .waddr (ptr),
    .wdata (in_data),
    .raddr (gray_addr),
    .rdata (img_rdata)
  );

  lbp_frame_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_res (
    .clk   (clk),
    .we    (res_we),
    .waddr (res_waddr),
    .wdata (res_wdata),
    .raddr (res_raddr),
    .rdata (res_rdata)
  );

  assign gray_data = ((state == SERVE) && gray_req) ? img_rdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr        <= '0;
      in_ready   <= 1'b0;
      gray_ready <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      lbp_wr_cnt <= '0;
      done       <= 1'b0;
    end else begin
      in_ready   <= (state_next == LOAD);
      gray_ready <= (state_next == SERVE);
      if (lbp_take && (lbp_wr_cnt != '1)) lbp_wr_cnt <= lbp_wr_cnt + 1'b1;
      case (state)
        LOAD: begin
          if (load_xfer) ptr <= (ptr == LAST_ADDR) ? '0 : ptr_inc;
        end
        DRAIN: begin
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_data  <= res_rdata;
            out_last  <= (ptr == LAST_ADDR);
          end else if (out_ready) begin
            if (out_last) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              ptr      <= ptr_inc;
              out_data <= res_rdata;
              out_last <= (ptr_inc == LAST_ADDR);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
